// File: rtl/alu_pkg.sv
// Shared opcode encoding, flag bundle and helpers for the pipelined ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Opcode encoding; values above OP_LAST are illegal and flagged as errors.
  typedef enum logic [3:0] {
    OP_ADD    = 4'h0,
    OP_SUB    = 4'h1,
    OP_XOR    = 4'h2,
    OP_RED    = 4'h3,
    OP_SLL    = 4'h4,
    OP_SRA    = 4'h5,
    OP_ROR    = 4'h6,
    OP_PADDSB = 4'h7,
    OP_LLB    = 4'h8,
    OP_LHB    = 4'h9
  } alu_op_e;

  localparam logic [3:0] OP_LAST = 4'h9;

  // Committed / pending condition flags.
  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } alu_flags_t;

  // Opcode legality check shared by the datapath.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_LAST);
  endfunction

endpackage

// File: rtl/alu_pipe_core_comb.sv
// Purely combinational evaluation of one ALU operation at any byte-multiple width.
// Latency: 0 cycles (combinational).
// Backpressure: none; the surrounding pipeline decides when results are captured.
module alu_core_comb
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SAT_ARITH = 1'b0
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             err_o,
  output logic             ovf_o,
  output logic             upd_zn_o,
  output logic             upd_v_o
);

  localparam int SHW    = $clog2(WIDTH);
  localparam int NBYTES = WIDTH / 8;
  localparam int NLANES = WIDTH / 4;

  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  alu_op_e op;
  assign op = alu_op_e'(op_i);

  // Shift amount uses only the low log2(WIDTH) bits of the second operand.
  logic [SHW-1:0] sh;
  assign sh = b_i[SHW-1:0];

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_ovf;
  logic             sub_ovf;
  logic [WIDTH-1:0] sat_val;

  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;

  // Overflow: add of same-signed operands, or sub of opposite-signed ones, flips sign.
  assign add_ovf = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1]  != a_i[WIDTH-1]);
  assign sub_ovf = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);

  // On overflow the true result carries the sign of in1 in both ADD and SUB.
  assign sat_val = a_i[WIDTH-1] ? SMIN : SMAX;

  logic signed [WIDTH-1:0] a_sgn;
  logic        [WIDTH-1:0] sll_res;
  logic        [WIDTH-1:0] sra_res;
  logic        [WIDTH-1:0] ror_res;

  assign a_sgn   = a_i;
  assign sll_res = a_i << sh;
  assign sra_res = a_sgn >>> sh;
  // Amount 0 shifts the left half out entirely, so rotate-by-0 returns in1.
  assign ror_res = (a_i >> sh) | (a_i << (WIDTH - int'(sh)));

  // Reduction: sign-extended sum of every byte of both operands.
  logic [WIDTH-1:0] red_res;
  always_comb begin
    red_res = '0;
    for (int i = 0; i < NBYTES; i++) begin
      red_res = red_res
              + {{(WIDTH-8){a_i[8*i+7]}}, a_i[8*i +: 8]}
              + {{(WIDTH-8){b_i[8*i+7]}}, b_i[8*i +: 8]};
    end
  end

  // Packed add: independent signed nibble lanes, each clamped to [-8, +7].
  logic [WIDTH-1:0] padd_res;
  logic [4:0]       lane_sum;
  always_comb begin
    padd_res = '0;
    lane_sum = '0;
    for (int i = 0; i < NLANES; i++) begin
      lane_sum = {a_i[4*i+3], a_i[4*i +: 4]} + {b_i[4*i+3], b_i[4*i +: 4]};
      if (lane_sum[4] != lane_sum[3]) begin
        padd_res[4*i +: 4] = lane_sum[4] ? 4'h8 : 4'h7;
      end else begin
        padd_res[4*i +: 4] = lane_sum[3:0];
      end
    end
  end

  // Result select plus which flags this opcode is allowed to commit.
  always_comb begin
    res_o    = '0;
    err_o    = !op_is_legal(op_i);
    ovf_o    = 1'b0;
    upd_zn_o = 1'b0;
    upd_v_o  = 1'b0;
    case (op)
      OP_ADD: begin
        res_o    = (SAT_ARITH && add_ovf) ? sat_val : sum;
        ovf_o    = add_ovf;
        upd_zn_o = 1'b1;
        upd_v_o  = 1'b1;
      end
      OP_SUB: begin
        res_o    = (SAT_ARITH && sub_ovf) ? sat_val : diff;
        ovf_o    = sub_ovf;
        upd_zn_o = 1'b1;
        upd_v_o  = 1'b1;
      end
      OP_XOR: begin
        res_o    = a_i ^ b_i;
        upd_zn_o = 1'b1;
      end
      OP_RED:    res_o = red_res;
      OP_SLL: begin
        res_o    = sll_res;
        upd_zn_o = 1'b1;
      end
      OP_SRA: begin
        res_o    = sra_res;
        upd_zn_o = 1'b1;
      end
      OP_ROR: begin
        res_o    = ror_res;
        upd_zn_o = 1'b1;
      end
      OP_PADDSB: res_o = padd_res;
      OP_LLB:    res_o = {a_i[WIDTH-1:8], b_i[7:0]};
      OP_LHB:    res_o = {b_i[7:0], a_i[WIDTH-9:0]};
      default:   res_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshake, sticky Z/N/V flags and illegal-op error.
// Latency: 2 cycles from input accept to out_valid; 1 op/cycle throughput.
// Backpressure: out_ready low freezes stage 2 and, once stage 1 is full, deasserts in_ready.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit SAT_ARITH = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       aluop,
  input  logic [WIDTH-1:0] aluin1,
  input  logic [WIDTH-1:0] aluin2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] aluout,
  output logic             err,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_v
);

  // Stage 1: captured opcode and operands.
  logic             s1_vld_q, s1_vld_d;
  logic [3:0]       s1_op_q;
  logic [WIDTH-1:0] s1_a_q;
  logic [WIDTH-1:0] s1_b_q;

  // Stage 2: final result, error and flag values waiting for the output handshake.
  logic             s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0] s2_res_q;
  logic             s2_err_q;
  logic             s2_upd_zn_q;
  logic             s2_upd_v_q;
  alu_flags_t       s2_pflags_q;

  alu_flags_t       flags_q, flags_d;

  logic             s2_adv;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  // Stall chain: only registered state and out_ready feed in_ready.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_adv   = s2_adv || !s2_vld_q;
  assign in_ready = !s1_vld_q || s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = s2_vld_q && out_ready;

  logic [WIDTH-1:0] core_res;
  logic             core_err;
  logic             core_ovf;
  logic             core_upd_zn;
  logic             core_upd_v;

  alu_core_comb #(
    .WIDTH    (WIDTH),
    .SAT_ARITH(SAT_ARITH)
  ) u_core (
    .op_i    (s1_op_q),
    .a_i     (s1_a_q),
    .b_i     (s1_b_q),
    .res_o   (core_res),
    .err_o   (core_err),
    .ovf_o   (core_ovf),
    .upd_zn_o(core_upd_zn),
    .upd_v_o (core_upd_v)
  );

  // Next-state for the pipeline valids and the committed flags.
  always_comb begin
    s1_vld_d = s1_vld_q;
    s2_vld_d = s2_vld_q;
    flags_d  = flags_q;
    if (in_ready) begin
      s1_vld_d = in_valid;
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
    end
    if (out_fire) begin
      if (s2_upd_zn_q) begin
        flags_d.z = s2_pflags_q.z;
        flags_d.n = s2_pflags_q.n;
      end
      if (s2_upd_v_q) begin
        flags_d.v = s2_pflags_q.v;
      end
    end
  end

  // Valid bits and committed flags; reset discards anything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      flags_q  <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      flags_q  <= flags_d;
    end
  end

  // Stage 1 operand capture on every accepted input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_op_q <= '0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
    end else if (in_fire) begin
      s1_op_q <= aluop;
      s1_a_q  <= aluin1;
      s1_b_q  <= aluin2;
    end
  end

  // Stage 2 result capture; held untouched while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_res_q    <= '0;
      s2_err_q    <= 1'b0;
      s2_upd_zn_q <= 1'b0;
      s2_upd_v_q  <= 1'b0;
      s2_pflags_q <= '0;
    end else if (s2_adv && s1_vld_q) begin
      s2_res_q      <= core_res;
      s2_err_q      <= core_err;
      s2_upd_zn_q   <= core_upd_zn;
      s2_upd_v_q    <= core_upd_v;
      s2_pflags_q.z <= (core_res == '0);
      s2_pflags_q.n <= core_res[WIDTH-1];
      s2_pflags_q.v <= core_ovf;
    end
  end

  assign out_valid = s2_vld_q;
  assign aluout    = s2_res_q;
  assign err       = s2_err_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_v    = flags_q.v;

endmodule
